score_display: RTL and testbench

Time-multiplexed driver for the 4-digit common-anode seven-segment display. Consumes the three BCD score digits produced by the binary-to-BCD converter, plus a lives count, and scans them onto shared active-low segment lines with one anode enabled at a time. Inputs are snapshotted once per scan frame so a digit never tears mid-frame. An anti-ghosting blank interval opens each digit slot.

---
 rtl/score_display_pkg.sv | 34 +++
 rtl/score_display_seg7_decode.sv | 28 ++
 rtl/score_display.sv | 143 ++++++++++++++
 tb/tb_score_display.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/score_display_pkg.sv
// score_display_pkg: shared types and constants for the seven-segment scanner.
// Glyphs are active-low, bit 0 = segment a ... bit 6 = segment g.
package score_display_pkg;

  typedef logic [1:0] digit_idx_t;

  // Digit positions on the display, an[0] is the rightmost digit.
  localparam digit_idx_t DIG_ONES     = 2'd0;
  localparam digit_idx_t DIG_TENS     = 2'd1;
  localparam digit_idx_t DIG_HUNDREDS = 2'd2;
  localparam digit_idx_t DIG_LIVES    = 2'd3;

  // Active-low glyphs (gfedcba).
  localparam logic [6:0] SEG_0    = 7'h40;
  localparam logic [6:0] SEG_1    = 7'h79;
  localparam logic [6:0] SEG_2    = 7'h24;
  localparam logic [6:0] SEG_3    = 7'h30;
  localparam logic [6:0] SEG_4    = 7'h19;
  localparam logic [6:0] SEG_5    = 7'h12;
  localparam logic [6:0] SEG_6    = 7'h02;
  localparam logic [6:0] SEG_7    = 7'h78;
  localparam logic [6:0] SEG_8    = 7'h00;
  localparam logic [6:0] SEG_9    = 7'h10;
  localparam logic [6:0] SEG_DASH = 7'h3F;
  localparam logic [6:0] SEG_OFF  = 7'h7F;

  // Active-low anode pattern enabling only the given digit.
  function automatic logic [3:0] anode_sel_n(input digit_idx_t idx);
    logic [3:0] onehot;
    onehot = 4'b0001 << idx;
    return ~onehot;
  endfunction

endpackage

// File: rtl/score_display_seg7_decode.sv
// seg7_decode: combinational BCD to active-low seven-segment glyph.
// Values above 9 are not valid BCD and render as a dash.
module seg7_decode
  import score_display_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg_n
);

  // Glyph lookup; the default arm covers 10..15.
  always_comb begin
    seg_n = SEG_DASH;
    case (bcd)
      4'd0: seg_n = SEG_0;
      4'd1: seg_n = SEG_1;
      4'd2: seg_n = SEG_2;
      4'd3: seg_n = SEG_3;
      4'd4: seg_n = SEG_4;
      4'd5: seg_n = SEG_5;
      4'd6: seg_n = SEG_6;
      4'd7: seg_n = SEG_7;
      4'd8: seg_n = SEG_8;
      4'd9: seg_n = SEG_9;
      default: seg_n = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/score_display.sv
// score_display: time-multiplexed 4-digit common-anode seven-segment driver.
// Digits: 0 = ones, 1 = tens, 2 = hundreds, 3 = lives (with decimal point).
// Inputs are snapshotted once per frame (4 slots) so a digit never tears.
// Optional feature: define SCORE_LEADING_ZERO_BLANK_EN to blank leading zeros
// of the score (hundreds, then tens). Default build shows all four digits.
module score_display
  import score_display_pkg::*;
#(
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] hundreds,
  input  logic [3:0] tens,
  input  logic [3:0] ones,
  input  logic [3:0] lives,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_tick
);

  localparam int unsigned CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LIM = CNT_W'(BLANK_CYCLES);

  // Scan position.
  logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
  digit_idx_t       digit_idx_q, digit_idx_d;

  // Frame shadow registers; the only source of displayed data.
  logic [3:0] sh_hundreds_q, sh_hundreds_d;
  logic [3:0] sh_tens_q, sh_tens_d;
  logic [3:0] sh_ones_q, sh_ones_d;
  logic [3:0] sh_lives_q, sh_lives_d;

  // Registered outputs.
  logic [3:0] an_q, an_d;
  logic [6:0] seg_q, seg_d;
  logic       dp_q, dp_d;
  logic       frame_tick_q, frame_tick_d;

  logic       slot_wrap;
  logic       snapshot;
  logic [3:0] digit_val;
  logic [6:0] digit_glyph;
  logic       digit_blank;
  logic       in_blank_window;

  // Prescaler and digit index; snapshot when the last slot of a frame ends.
  always_comb begin
    slot_wrap    = (div_cnt_q == CNT_LAST);
    div_cnt_d    = slot_wrap ? '0 : div_cnt_q + CNT_W'(1);
    digit_idx_d  = slot_wrap ? digit_idx_q + 2'd1 : digit_idx_q;
    snapshot     = slot_wrap && (digit_idx_q == DIG_LIVES);
    frame_tick_d = snapshot;
  end

  // Shadow registers load all four digits together at the frame boundary.
  always_comb begin
    sh_hundreds_d = sh_hundreds_q;
    sh_tens_d     = sh_tens_q;
    sh_ones_d     = sh_ones_q;
    sh_lives_d    = sh_lives_q;
    if (snapshot) begin
      sh_hundreds_d = hundreds;
      sh_tens_d     = tens;
      sh_ones_d     = ones;
      sh_lives_d    = lives;
    end
  end

  // Select the shadow digit for the slot currently being scanned.
  always_comb begin
    digit_val = sh_ones_q;
    case (digit_idx_q)
      DIG_ONES:     digit_val = sh_ones_q;
      DIG_TENS:     digit_val = sh_tens_q;
      DIG_HUNDREDS: digit_val = sh_hundreds_q;
      DIG_LIVES:    digit_val = sh_lives_q;
      default:      digit_val = sh_ones_q;
    endcase
  end

  seg7_decode u_decode (
    .bcd   (digit_val),
    .seg_n (digit_glyph)
  );

  // Leading-zero suppression; invalid BCD compares non-zero and stays visible.
  always_comb begin
`ifdef SCORE_LEADING_ZERO_BLANK_EN
    digit_blank = ((digit_idx_q == DIG_HUNDREDS) && (sh_hundreds_q == 4'd0)) ||
                  ((digit_idx_q == DIG_TENS) && (sh_hundreds_q == 4'd0) &&
                   (sh_tens_q == 4'd0));
`else
    digit_blank = 1'b0;
`endif
  end

  // Output drive: anodes off during the anti-ghost window or a blanked slot;
  // the decimal point follows the lives anode so it never lights while dark.
  always_comb begin
    in_blank_window = (div_cnt_q < BLANK_LIM);
    an_d  = (in_blank_window || digit_blank) ? 4'hF : anode_sel_n(digit_idx_q);
    seg_d = digit_blank ? SEG_OFF : digit_glyph;
    dp_d  = an_d[DIG_LIVES];
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_q     <= '0;
      digit_idx_q   <= DIG_ONES;
      sh_hundreds_q <= 4'd0;
      sh_tens_q     <= 4'd0;
      sh_ones_q     <= 4'd0;
      sh_lives_q    <= 4'd0;
      an_q          <= 4'hF;
      seg_q         <= SEG_OFF;
      dp_q          <= 1'b1;
      frame_tick_q  <= 1'b0;
    end else begin
      div_cnt_q     <= div_cnt_d;
      digit_idx_q   <= digit_idx_d;
      sh_hundreds_q <= sh_hundreds_d;
      sh_tens_q     <= sh_tens_d;
      sh_ones_q     <= sh_ones_d;
      sh_lives_q    <= sh_lives_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
      frame_tick_q  <= frame_tick_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_score_display.sv
// tb_score_display: scoreboard bench for score_display (REFRESH_DIV=8,
// BLANK_CYCLES=2). A reference model predicts every output cycle from
// elapsed time since reset and the inputs seen at each frame boundary.
module tb_score_display;

  localparam int R  = 8;
  localparam int B  = 2;
  localparam int FR = 4 * R;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] hundreds = 4'd0, tens = 4'd0, ones = 4'd0, lives = 4'd0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       frame_tick;

  int checks = 0;
  int errors = 0;

  score_display #(.REFRESH_DIV(R), .BLANK_CYCLES(B)) dut (
    .clk        (clk),
    .reset      (reset),
    .hundreds   (hundreds),
    .tens       (tens),
    .ones       (ones),
    .lives      (lives),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       ft;
    int         k;
  } exp_t;

  exp_t expq[$];

  // Model state: edges since reset release and displayed digit values by slot.
  int k = 0;
  int sh[4];

  // Glyph from the list of lit segment letters.
  function automatic logic [6:0] glyph(input int v);
    string s;
    logic [6:0] lit;
    case (v)
      0: s = "abcdef";
      1: s = "bc";
      2: s = "abdeg";
      3: s = "abcdg";
      4: s = "bcfg";
      5: s = "acdfg";
      6: s = "acdefg";
      7: s = "abc";
      8: s = "abcdefg";
      9: s = "abcdfg";
      default: s = "g";
    endcase
    lit = '0;
    for (int i = 0; i < s.len(); i++) lit[s[i] - "a"] = 1'b1;
    return ~lit;
  endfunction

  function automatic bit slot_blank(input int slot, input int h, input int t);
`ifdef SCORE_LEADING_ZERO_BLANK_EN
    if (slot == 2) return h == 0;
    if (slot == 1) return (h == 0) && (t == 0);
    return 1'b0;
`else
    return 1'b0;
`endif
  endfunction

  // Predictor: one expected output set per clock edge.
  initial begin
    exp_t e;
    int pos, slot, cnt;
    bit blk, en;
    logic [3:0] oh;
    sh = '{0, 0, 0, 0};
    forever begin
      @(posedge clk);
      if (reset) begin
        k = 0;
        sh = '{0, 0, 0, 0};
        e = '{an: 4'hF, seg: 7'h7F, dp: 1'b1, ft: 1'b0, k: 0};
      end else begin
        k++;
        pos  = (k - 1) % FR;
        slot = pos / R;
        cnt  = pos % R;
        blk  = slot_blank(slot, sh[2], sh[1]);
        en   = !(cnt < B) && !blk;
        oh   = 4'b0001 << slot;
        e.an  = en ? ~oh : 4'hF;
        e.seg = blk ? 7'h7F : glyph(sh[slot]);
        e.dp  = !(en && slot == 3);
        e.ft  = (k % FR == 0);
        e.k   = k;
        if (k % FR == 0) sh = '{int'(ones), int'(tens), int'(hundreds), int'(lives)};
      end
      expq.push_back(e);
    end
  end

  task automatic cmp(input string name, input int kk, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s k=%0d actual=%h required=%h", name, kk, act, req);
    end
  endtask

  // Monitor: compare DUT outputs mid-cycle against the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        cmp("an", e.k, {4'h0, an}, {4'h0, e.an});
        cmp("seg", e.k, {1'b0, seg}, {1'b0, e.seg});
        cmp("dp", e.k, {7'h0, dp}, {7'h0, e.dp});
        cmp("frame_tick", e.k, {7'h0, frame_tick}, {7'h0, e.ft});
      end
    end
  end

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_score(input int h, input int t, input int o, input int l);
    hundreds = 4'(h); tens = 4'(t); ones = 4'(o); lives = 4'(l);
  endtask

  // Stimulus.
  initial begin
    bit found;
    run(3);
    reset = 1'b0;
    run(32);                       // blank scan with zero shadows
    set_score(4, 0, 7, 3);         // applied during frame 1
    run(40);
    ones = 4'd8;                   // mid-frame change
    run(64);
    set_score(0, 0, 5, 2);
    run(64);
    set_score(0, 1, 0, 9);
    run(64);
    set_score(2, 12, 6, 1);        // invalid BCD tens
    run(64);
    set_score(0, 12, 3, 4);        // dash must not count as a leading zero
    run(64);
    set_score(9, 9, 9, 15);
    run(20);
    // One-cycle reset during digit 2's slot.
    found = 1'b0;
    for (int i = 0; i < 2 * FR; i++) begin
      if ((k % FR) / R == 2 && (k % R) == 3) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL reset_slot2_window actual=notfound required=found");
    end
    reset = 1'b1;
    run(1);
    reset = 1'b0;
    run(72);
    // Randomized inputs changing at random times.
    for (int f = 0; f < 20; f++) begin
      for (int c = 0; c < FR; c++) begin
        if ($urandom_range(0, 7) == 0) begin
          case ($urandom_range(0, 3))
            0: hundreds = 4'($urandom_range(0, 15));
            1: tens     = 4'($urandom_range(0, 15));
            2: ones     = 4'($urandom_range(0, 15));
            default: lives = 4'($urandom_range(0, 15));
          endcase
        end
        if ($urandom_range(0, 3) == 0) begin
          if ($urandom_range(0, 1) == 0) hundreds = 4'd0;
          else tens = 4'd0;
        end
        @(negedge clk);
      end
    end
    run(2);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
